// File: rtl/bsg_two_fifo_width_p8_if.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo_width_p8_if
// Handshake bundle for the two-entry FIFO.
//   Producer side : v_i, data_i  (into FIFO), ready_o (out of FIFO)
//   Consumer side : v_o, data_o  (out of FIFO), yumi_i (into FIFO)
// Modports:
//   slave  - the FIFO itself
//   master - the agent that drives the producer inputs and the consumer yumi
// ---------------------------------------------------------------------------
interface bsg_two_fifo_width_p8_if #(
  parameter int width_p = 8
);
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport slave (
    input  v_i,
    input  data_i,
    input  yumi_i,
    output ready_o,
    output v_o,
    output data_o
  );

  modport master (
    output v_i,
    output data_i,
    output yumi_i,
    input  ready_o,
    input  v_o,
    input  data_o
  );
endinterface

// File: rtl/bsg_two_fifo_width_p8.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo_width_p8
// Two-entry registered FIFO. Producer enqueues with valid/ready, consumer
// dequeues with valid/yumi. data_o comes straight from a storage register,
// so there is no combinational path from data_i to data_o; data written at
// edge N is visible the cycle after edge N.
// Ports:
//   clk_i    - clock, all state changes on rising edge
//   reset_i  - synchronous active-high reset (forces ready_o=0, v_o=0)
//   io       - handshake bundle (slave modport):
//                v_i / data_i / ready_o : producer side
//                v_o / data_o / yumi_i  : consumer side
// Parameters:
//   width_p                 - data width
//   allow_enq_deq_on_full_p - 1: ready_o = ~full | yumi_i, 0: ready_o = ~full
// ---------------------------------------------------------------------------
module bsg_two_fifo_width_p8 #(
  parameter int width_p                 = 8,
  parameter int allow_enq_deq_on_full_p = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  bsg_two_fifo_width_p8_if.slave         io
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic               r_full;
  logic               r_empty;

  logic               w_enq;
  logic               w_deq;
  logic               w_ready;
  logic               w_allow;

  assign w_allow = (allow_enq_deq_on_full_p != 0);

  // A yumi on an empty FIFO is a protocol violation; gating with ~r_empty
  // keeps it from corrupting the pointers.
  assign w_deq   = io.yumi_i & ~r_empty & ~reset_i;

  // When full and enq-on-deq is allowed, the incoming word lands in the slot
  // being freed this cycle (r_wptr == r_rptr when full).
  assign w_ready = ~reset_i & (~r_full | (w_allow & w_deq));
  assign w_enq   = io.v_i & w_ready;

  assign io.ready_o = w_ready;
  assign io.v_o     = ~r_empty & ~reset_i;
  assign io.data_o  = r_mem[r_rptr];

  // Control state: pointers and flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      unique case ({w_enq, w_deq})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (~r_wptr == r_rptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (~r_rptr == r_wptr);
        end
        default: begin
          r_full  <= r_full;
          r_empty <= r_empty;
        end
      endcase
    end
  end

  // Storage: not reset, written only on a completed enqueue
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= io.data_i;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!io.yumi_i || !r_empty)
        else $error("bsg_two_fifo: yumi_i asserted while v_o is low");
      assert (!w_enq || !$isunknown(io.data_i))
        else $error("bsg_two_fifo: data_i has X on enqueue");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_two_fifo_width_p8.sv
// ---------------------------------------------------------------------------
// tb_bsg_two_fifo_width_p8
// Bench for two FIFO instances sharing producer stimulus: dut0 with
// allow_enq_deq_on_full_p=0 and dut1 with allow_enq_deq_on_full_p=1.
// Each has its own yumi. A queue model per instance predicts v_o, ready_o
// and data_o; directed sections also carry literal expectations.
// ---------------------------------------------------------------------------
module tb_bsg_two_fifo_width_p8;

  logic       clk;
  logic       rst;
  logic       v;
  logic [7:0] din;
  logic       yumi0;
  logic       yumi1;

  int checks = 0;
  int errs   = 0;
  bit started = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit e0, d0, e1, d1;

  bsg_two_fifo_width_p8_if #(.width_p(8)) f0 ();
  bsg_two_fifo_width_p8_if #(.width_p(8)) f1 ();

  assign f0.v_i    = v;
  assign f0.data_i = din;
  assign f0.yumi_i = yumi0;
  assign f1.v_i    = v;
  assign f1.data_i = din;
  assign f1.yumi_i = yumi1;

  bsg_two_fifo_width_p8 #(.width_p(8), .allow_enq_deq_on_full_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .io(f0)
  );
  bsg_two_fifo_width_p8 #(.width_p(8), .allow_enq_deq_on_full_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .io(f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Queue model: a dequeue pops the head, an enqueue appends. Capacity two.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      started = 1;
    end else if (started) begin
      d0 = yumi0 && (q0.size() > 0);
      e0 = v && (q0.size() < 2);
      d1 = yumi1 && (q1.size() > 0);
      e1 = v && ((q1.size() < 2) || d1);
      if (d0) void'(q0.pop_front());
      if (e0) q0.push_back(din);
      if (d1) void'(q1.pop_front());
      if (e1) q1.push_back(din);
    end
  end

  // Compare DUT outputs against the model every cycle once reset has been seen
  always @(negedge clk) begin
    if (started) begin
      chk1("m_v0",     f0.v_o,     !rst && (q0.size() > 0));
      chk1("m_ready0", f0.ready_o, !rst && (q0.size() < 2));
      chk1("m_v1",     f1.v_o,     !rst && (q1.size() > 0));
      chk1("m_ready1", f1.ready_o, !rst && ((q1.size() < 2) || (yumi1 && q1.size() > 0)));
      if (!rst && q0.size() > 0) chk8("m_data0", f0.data_o, q0[0]);
      if (!rst && q1.size() > 0) chk8("m_data1", f1.data_o, q1[0]);
    end
  end

  initial begin
    rst = 1'b1; v = 1'b0; din = 8'h00; yumi0 = 1'b0; yumi1 = 1'b0;
    nxt();
    @(negedge clk);
    chk1("rst_ready0", f0.ready_o, 1'b0);
    chk1("rst_v0",     f0.v_o,     1'b0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_v0",     f0.v_o,     1'b0);
    chk1("post_rst_ready0", f0.ready_o, 1'b1);

    // single push / pop
    nxt();
    v = 1'b1; din = 8'hA5;
    nxt();
    v = 1'b0;
    @(negedge clk);
    chk1("t1_v0",     f0.v_o,     1'b1);
    chk8("t1_data0",  f0.data_o,  8'hA5);
    chk1("t1_ready0", f0.ready_o, 1'b1);
    nxt();
    yumi0 = 1'b1; yumi1 = 1'b1;
    nxt();
    yumi0 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk1("t1_v0_after_pop", f0.v_o, 1'b0);

    // fill, stall the producer, drain
    nxt();
    v = 1'b1; din = 8'h11;
    nxt();
    din = 8'h22;
    nxt();
    din = 8'h33;
    @(negedge clk);
    chk1("t2_ready0_full", f0.ready_o, 1'b0);
    chk8("t2_head",        f0.data_o,  8'h11);
    nxt(); nxt(); nxt();
    v = 1'b0;
    @(negedge clk);
    chk8("t2_head_held", f0.data_o, 8'h11);
    nxt();
    yumi0 = 1'b1; yumi1 = 1'b1;
    @(negedge clk);
    chk8("t2_pop1", f0.data_o, 8'h11);
    nxt();
    @(negedge clk);
    chk8("t2_pop2", f0.data_o, 8'h22);
    nxt();
    yumi0 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk1("t2_empty", f0.v_o, 1'b0);

    // streaming: enqueue and dequeue every cycle
    nxt();
    v = 1'b1; din = 8'h00;
    nxt();
    for (int i = 1; i < 16; i++) begin
      din = 8'(i); yumi0 = 1'b1; yumi1 = 1'b1;
      @(negedge clk);
      chk8("t3_stream", f0.data_o, 8'(i - 1));
      chk1("t3_ready",  f0.ready_o, 1'b1);
      nxt();
    end
    v = 1'b0;
    @(negedge clk);
    chk8("t3_last", f0.data_o, 8'h0F);
    nxt();
    yumi0 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk1("t3_empty", f0.v_o, 1'b0);

    // enq + deq while full
    nxt();
    v = 1'b1; din = 8'h01;
    nxt();
    din = 8'h02;
    nxt();
    din = 8'h03; yumi0 = 1'b1; yumi1 = 1'b1;
    @(negedge clk);
    chk1("t4_ready1", f1.ready_o, 1'b1);
    chk1("t4_ready0", f0.ready_o, 1'b0);
    chk8("t4_head1",  f1.data_o,  8'h01);
    nxt();
    v = 1'b0; yumi0 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk1("t4_still_full1", f1.ready_o, 1'b0);
    chk1("t4_v1",          f1.v_o,     1'b1);
    chk8("t4_head1_b",     f1.data_o,  8'h02);
    chk8("t4_head0_b",     f0.data_o,  8'h02);
    nxt();
    yumi0 = 1'b1; yumi1 = 1'b1;
    nxt();
    yumi0 = 1'b0;
    @(negedge clk);
    chk8("t4_head1_c", f1.data_o, 8'h03);
    chk1("t4_v0_empty", f0.v_o, 1'b0);
    nxt();
    yumi1 = 1'b0;
    @(negedge clk);
    chk1("t4_v1_empty", f1.v_o, 1'b0);

    // reset while full with v_i and yumi_i asserted
    nxt();
    v = 1'b1; din = 8'hAA;
    nxt();
    din = 8'hBB;
    nxt();
    rst = 1'b1; yumi0 = 1'b1; yumi1 = 1'b1;
    @(negedge clk);
    chk1("t5_rst_ready0", f0.ready_o, 1'b0);
    chk1("t5_rst_v0",     f0.v_o,     1'b0);
    chk1("t5_rst_ready1", f1.ready_o, 1'b0);
    chk1("t5_rst_v1",     f1.v_o,     1'b0);
    nxt();
    rst = 1'b0; v = 1'b0; yumi0 = 1'b0; yumi1 = 1'b0;
    @(negedge clk);
    chk1("t5_v0",     f0.v_o,     1'b0);
    chk1("t5_ready0", f0.ready_o, 1'b1);
    chk1("t5_v1",     f1.v_o,     1'b0);
    chk1("t5_ready1", f1.ready_o, 1'b1);

    // random traffic, yumi only when the model says data is present
    nxt();
    for (int i = 0; i < 10000; i++) begin
      v     = 1'($urandom_range(0, 1));
      din   = 8'($urandom);
      yumi0 = (q0.size() > 0) && ($urandom_range(0, 1) == 1);
      yumi1 = (q1.size() > 0) && ($urandom_range(0, 1) == 1);
      nxt();
    end
    v = 1'b0; yumi0 = 1'b0; yumi1 = 1'b0;
    nxt();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/bsg_two_fifo_width_p8.md
Name: bsg_two_fifo_width_p8

Overview:
Two-entry registered FIFO that forms the consumer-facing end of the enable-written register path used across the design. The producer writes with a valid/ready handshake. The consumer drains with a valid/yumi handshake. It decouples timing between a pipeline stage that holds data and the stage that reads it, and it is the standard small elastic buffer between units.

Parameters:
width_p, 8, data width in bits (legal range 1 and up)
allow_enq_deq_on_full_p, 0, if 1 then ready_o = ~full | yumi_i (combinational path from yumi_i to ready_o); if 0 then ready_o = ~full only

Ports:
clk_i  input  1  clock; all state updates on its rising edge
reset_i  input  1  synchronous, active-high reset
v_i  input  1  producer data valid
ready_o  output  1  FIFO can accept data this cycle
data_i  input  width_p  producer data
v_o  output  1  head entry valid
data_o  output  width_p  head entry data
yumi_i  input  1  consumer takes the head entry this cycle (legal only when v_o=1)

Behaviour:
- State:
  - two storage registers mem[0..1], each width_p wide
  - 1-bit write pointer wptr_r and 1-bit read pointer rptr_r
  - full_r and empty_r flags
  - storage registers are not reset
- Reset (reset_i=1 at a rising edge): wptr_r=0, rptr_r=0, empty_r=1, full_r=0.
- While reset_i=1:
  - ready_o is forced to 0 and v_o is forced to 0
  - v_i and yumi_i are ignored and no write occurs
- After reset: v_o=0 and ready_o=1; data_o is don't-care while v_o=0.
- Handshake definitions:
  - enq = v_i & ready_o
  - deq = yumi_i & v_o
- Enqueue (enq=1): mem[wptr_r] <= data_i and wptr_r toggles.
- Dequeue (deq=1): rptr_r toggles.
- Outputs:
  - v_o = ~empty_r
  - data_o = mem[rptr_r], driven directly from a register with no combinational path from data_i
- Latency: data accepted at edge N appears on data_o with v_o=1 in the cycle after edge N. There is no same-cycle bypass.
- Flag update rules:
  - enq only: empty_r <= 0, and full_r <= (wptr_r+1 == rptr_r)
  - deq only: full_r <= 0, and empty_r <= (rptr_r+1 == wptr_r)
  - enq and deq together: flags unchanged and both pointers advance
  - neither: hold all state
- Boundary conditions:
  - Full with allow_enq_deq_on_full_p=0: ready_o=0, so a simultaneous v_i and yumi_i causes only a dequeue.
  - Full with allow_enq_deq_on_full_p=1: ready_o=yumi_i. Enq and deq in the same cycle write into the slot being freed (mem[wptr_r] == mem[rptr_r]). Afterwards the FIFO stays full and the head is the older remaining entry.
  - Empty: v_o=0. yumi_i=1 is a protocol violation; the block ignores it (deq=0), and the simulation assertion flags it.
  - Wrap-around: pointers are 1 bit and wrap naturally. Ordering is strict FIFO across any number of wraps.
  - Stability: while v_o=1 and yumi_i=0, data_o and v_o hold stable.
  - v_i asserted with ready_o=0: data_i is not captured; the producer must hold it.
  - Reset mid-operation: all contents are discarded and v_o=0 on the next cycle, regardless of v_i or yumi_i.
- Assertions (simulation only, suppressed while reset_i=1):
  - yumi_i implies v_o
  - data_i has no X when enq=1

Test Plan:
- Reset, then push 8'hA5 with v_i=1 for one cycle -> next cycle v_o=1, data_o=8'hA5, ready_o=1; assert yumi_i -> following cycle v_o=0.
- Push 8'h11 then 8'h22 with no yumi -> ready_o=0 after second edge; hold v_i=1 with 8'h33 for 3 cycles -> nothing written; yumi twice -> data_o=8'h11 then 8'h22, then v_o=0.
- Continuous stream of 8'h00..8'h0F with v_i=1 and yumi_i=1 every cycle after the first -> output sequence identical and in order, one item per cycle, pointers wrap 8 times, full_r never set.
- allow_enq_deq_on_full_p=1: fill with 8'h01, 8'h02; next cycle v_i=1 with 8'h03 and yumi_i=1 -> ready_o=1, FIFO stays full, output order 02, 03.
- Fill with two entries, then assert reset_i for one cycle while v_i=1 and yumi_i=1 -> ready_o=0 and v_o=0 during reset; after release v_o=0, ready_o=1, and no stale data appears.
- Random v_i and yumi_i (yumi_i only when v_o) for 10k cycles against a scoreboard queue -> zero mismatches, and no yumi-without-valid assertions.
